// File: rtl/score_ram_arbiter.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : score_ram_arbiter
// Description : Round-robin arbiter between a score-update read-modify-write
//               and a full leaderboard scan of an 8 x 6 score RAM.
//               SCORE_CLEAR_EN : when defined, zero the RAM after reset.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module score_ram_arbiter (
   input  logic       clock,
   input  logic       rst,
   input  logic       upd_req,
   input  logic [2:0] upd_id,
   input  logic [5:0] upd_score,
   output logic       upd_ack,
   input  logic       scan_req,
   output logic       scan_done,
   output logic [2:0] max_id,
   output logic [5:0] max_score,
   output logic [2:0] ram_addr,
   output logic [5:0] ram_data,
   output logic       ram_wren,
   input  logic [5:0] ram_q,
   output logic       busy
);

   typedef enum logic [2:0] {
`ifdef SCORE_CLEAR_EN
      CLEAR    = 3'd0,
`endif
      IDLE     = 3'd1,
      UPD_RD   = 3'd2,
      UPD_WR   = 3'd3,
      SCAN_RD  = 3'd4,
      SCAN_END = 3'd5
   } state_t;

`ifdef SCORE_CLEAR_EN
   localparam state_t RESET_STATE = CLEAR;
`else
   localparam state_t RESET_STATE = IDLE;
`endif

   state_t     state_q, state_d;
   logic       last_scan_q, last_scan_d;
   logic [2:0] addr_q, addr_d;
   logic [2:0] id_q, id_d;
   logic [5:0] score_q, score_d;
   logic [2:0] best_id_q, best_id_d;
   logic [5:0] best_score_q, best_score_d;
   logic [2:0] max_id_q, max_id_d;
   logic [5:0] max_score_q, max_score_d;

   logic       grant_upd, grant_scan;
   logic [2:0] addr_out;
   logic [5:0] data_out;
   logic       wren_out, ack_out, done_out;
   logic [2:0] fin_id;
   logic [5:0] fin_score;

   // Ties go to whichever requester was not served last.
   assign grant_upd  = upd_req && (!scan_req || last_scan_q);
   assign grant_scan = scan_req && !grant_upd;

   always_comb begin
      state_d      = state_q;
      last_scan_d  = last_scan_q;
      addr_d       = addr_q;
      id_d         = id_q;
      score_d      = score_q;
      best_id_d    = best_id_q;
      best_score_d = best_score_q;
      max_id_d     = max_id_q;
      max_score_d  = max_score_q;
      addr_out     = 3'd0;
      data_out     = 6'd0;
      wren_out     = 1'b0;
      ack_out      = 1'b0;
      done_out     = 1'b0;
      fin_id       = best_id_q;
      fin_score    = best_score_q;

      case (state_q)
`ifdef SCORE_CLEAR_EN
         CLEAR: begin
            addr_out = addr_q;
            wren_out = 1'b1;
            addr_d   = addr_q + 3'd1;
            if (addr_q == 3'd7) state_d = IDLE;
         end
`endif
         IDLE: begin
            if (grant_upd) begin
               id_d        = upd_id;
               score_d     = upd_score;
               last_scan_d = 1'b0;
               state_d     = UPD_RD;
            end else if (grant_scan) begin
               addr_d       = 3'd0;
               best_id_d    = 3'd0;
               best_score_d = 6'd0;
               last_scan_d  = 1'b1;
               state_d      = SCAN_RD;
            end
         end
         UPD_RD: begin
            addr_out = id_q;
            state_d  = UPD_WR;
         end
         UPD_WR: begin
            addr_out = id_q;
            data_out = (ram_q > score_q) ? ram_q : score_q;
            wren_out = 1'b1;
            ack_out  = 1'b1;
            state_d  = IDLE;
         end
         SCAN_RD: begin
            addr_out = addr_q;
            // ram_q carries the entry addressed in the previous cycle.
            if (addr_q != 3'd0 && ram_q > best_score_q) begin
               best_id_d    = addr_q - 3'd1;
               best_score_d = ram_q;
            end
            addr_d = addr_q + 3'd1;
            if (addr_q == 3'd7) state_d = SCAN_END;
         end
         SCAN_END: begin
            if (ram_q > best_score_q) begin
               fin_id    = 3'd7;
               fin_score = ram_q;
            end
            max_id_d    = fin_id;
            max_score_d = fin_score;
            done_out    = 1'b1;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!rst) begin
         state_q      <= RESET_STATE;
         last_scan_q  <= 1'b1;
         addr_q       <= 3'd0;
         id_q         <= 3'd0;
         score_q      <= 6'd0;
         best_id_q    <= 3'd0;
         best_score_q <= 6'd0;
         max_id_q     <= 3'd0;
         max_score_q  <= 6'd0;
      end else begin
         state_q      <= state_d;
         last_scan_q  <= last_scan_d;
         addr_q       <= addr_d;
         id_q         <= id_d;
         score_q      <= score_d;
         best_id_q    <= best_id_d;
         best_score_q <= best_score_d;
         max_id_q     <= max_id_d;
         max_score_q  <= max_score_d;
      end
   end

   // Outputs are forced quiet for as long as reset is held, dropping any write.
   assign ram_addr  = rst ? addr_out : 3'd0;
   assign ram_data  = rst ? data_out : 6'd0;
   assign ram_wren  = rst ? wren_out : 1'b0;
   assign upd_ack   = rst ? ack_out  : 1'b0;
   assign scan_done = rst ? done_out : 1'b0;
   assign max_id    = !rst ? 3'd0 : (state_q == SCAN_END) ? fin_id    : max_id_q;
   assign max_score = !rst ? 6'd0 : (state_q == SCAN_END) ? fin_score : max_score_q;
   assign busy      = rst && (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_score_ram_arbiter.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_score_ram_arbiter
// Description : Scoreboard bench for score_ram_arbiter with a behavioural RAM.
//               Honours SCORE_CLEAR_EN when defined for the build.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_score_ram_arbiter;

   logic       clock = 1'b0;
   logic       rst;
   logic       upd_req, scan_req;
   logic [2:0] upd_id;
   logic [5:0] upd_score;
   logic       upd_ack, scan_done, ram_wren, busy;
   logic [2:0] max_id, ram_addr;
   logic [5:0] max_score, ram_data, ram_q;

   logic [5:0] mem [8];
   logic [5:0] model_mem [8];
   logic [8:0] upd_q [$];
   logic [8:0] scan_q [$];
   logic [8:0] mon_e;

   int n_vec = 0;
   int n_err = 0;

   always #5 clock = ~clock;

   score_ram_arbiter dut (
      .clock     (clock),
      .rst       (rst),
      .upd_req   (upd_req),
      .upd_id    (upd_id),
      .upd_score (upd_score),
      .upd_ack   (upd_ack),
      .scan_req  (scan_req),
      .scan_done (scan_done),
      .max_id    (max_id),
      .max_score (max_score),
      .ram_addr  (ram_addr),
      .ram_data  (ram_data),
      .ram_wren  (ram_wren),
      .ram_q     (ram_q),
      .busy      (busy)
   );

   // One-cycle read latency score RAM.
   always @(posedge clock) begin
      if (ram_wren) mem[ram_addr] <= ram_data;
      ram_q <= mem[ram_addr];
   end

   task automatic check(input string tag, input int obs, input int exp);
      n_vec++;
      if (obs != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic [8:0] scan_expect();
      logic [2:0] id = 3'd0;
      logic [5:0] best = 6'd0;
      for (int i = 0; i < 8; i++)
         if (model_mem[i] > best) begin
            best = model_mem[i];
            id   = 3'(i);
         end
      return {id, best};
   endfunction

   task automatic preload(input logic [5:0] v0, v1, v2, v3, v4, v5, v6, v7);
      logic [5:0] v [8];
      v = '{v0, v1, v2, v3, v4, v5, v6, v7};
      for (int i = 0; i < 8; i++) begin
         mem[i]       = v[i];
         model_mem[i] = v[i];
      end
   endtask

   task automatic push_update(input logic [2:0] id, input logic [5:0] sc);
      if (sc > model_mem[id]) model_mem[id] = sc;
      upd_q.push_back({id, model_mem[id]});
   endtask

   task automatic do_update(input logic [2:0] id, input logic [5:0] sc);
      int  n = 0;
      bit  got = 0;
      push_update(id, sc);
      upd_id = id; upd_score = sc; upd_req = 1'b1;
      while (!got && n < 20) begin
         @(posedge clock); @(negedge clock); n++;
         if (upd_ack) got = 1;
      end
      upd_req = 1'b0;
      check("upd_latency", got ? n : -1, 2);
      @(negedge clock);
   endtask

   task automatic do_scan();
      int  n = 0;
      bit  got = 0;
      logic [8:0] e;
      e = scan_expect();
      scan_q.push_back(e);
      scan_req = 1'b1;
      while (!got && n < 30) begin
         @(posedge clock); @(negedge clock); n++;
         if (scan_done) got = 1;
      end
      scan_req = 1'b0;
      check("scan_latency", got ? n : -1, 9);
      @(negedge clock);
      check("max_id_held", int'(max_id), int'(e[8:6]));
      check("max_score_held", int'(max_score), int'(e[5:0]));
   endtask

   task automatic tie_pair(input bit upd_first, input logic [2:0] id, input logic [5:0] sc);
      int n = 0;
      bit got_a = 0, got_d = 0;
      if (upd_first) begin
         push_update(id, sc);
         scan_q.push_back(scan_expect());
      end else begin
         scan_q.push_back(scan_expect());
         push_update(id, sc);
      end
      upd_id = id; upd_score = sc; upd_req = 1'b1; scan_req = 1'b1;
      while (!(got_a && got_d) && n < 60) begin
         @(posedge clock); @(negedge clock); n++;
         if (upd_ack && !got_a) begin
            got_a = 1; upd_req = 1'b0;
            check("tie_ack_latency", n, upd_first ? 2 : 12);
         end
         if (scan_done && !got_d) begin
            got_d = 1; scan_req = 1'b0;
            check("tie_done_latency", n, upd_first ? 12 : 9);
         end
      end
      upd_req = 1'b0; scan_req = 1'b0;
      if (!(got_a && got_d)) check("tie_timeout", 0, 1);
      @(negedge clock);
   endtask

   // Scoreboard: every ack/done pops the next expectation.
   always @(negedge clock) begin
      if (rst === 1'b1) begin
         if (upd_ack) begin
            if (upd_q.size() == 0) check("unexpected_ack", 1, 0);
            else begin
               mon_e = upd_q.pop_front();
               check("ack_addr", int'(ram_addr), int'(mon_e[8:6]));
               check("ack_data", int'(ram_data), int'(mon_e[5:0]));
               check("ack_wren", int'(ram_wren), 1);
            end
         end
         if (scan_done) begin
            if (scan_q.size() == 0) check("unexpected_done", 1, 0);
            else begin
               mon_e = scan_q.pop_front();
               check("done_max_id", int'(max_id), int'(mon_e[8:6]));
               check("done_max_score", int'(max_score), int'(mon_e[5:0]));
            end
         end
      end
   end

   initial begin
      int n;
      int writes;
      rst = 1'b0; upd_req = 1'b0; scan_req = 1'b0; upd_id = 3'd0; upd_score = 6'd0;
      preload(6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7, 6'd8);
      repeat (3) @(negedge clock);
      check("rst_busy", int'(busy), 0);
      check("rst_wren", int'(ram_wren), 0);
      check("rst_addr", int'(ram_addr), 0);
      check("rst_data", int'(ram_data), 0);
      check("rst_ack", int'(upd_ack), 0);
      check("rst_done", int'(scan_done), 0);
      check("rst_max_id", int'(max_id), 0);
      check("rst_max_score", int'(max_score), 0);

      rst = 1'b1;
      #1;
`ifdef SCORE_CLEAR_EN
      upd_req = 1'b1; scan_req = 1'b1;
      for (int k = 0; k < 8; k++) begin
         check("clr_wren", int'(ram_wren), 1);
         check("clr_addr", int'(ram_addr), k);
         check("clr_data", int'(ram_data), 0);
         check("clr_busy", int'(busy), 1);
         @(negedge clock);
      end
      upd_req = 1'b0; scan_req = 1'b0;
      #1;
      check("clr_done_busy", int'(busy), 0);
      for (int i = 0; i < 8; i++) model_mem[i] = 6'd0;
      do_scan();
`else
      check("post_rst_busy", int'(busy), 0);
      writes = 0;
      for (int k = 0; k < 8; k++) begin
         if (ram_wren) writes++;
         @(negedge clock);
      end
      check("post_rst_writes", writes, 0);
      check("ram_retained", int'(mem[7]), 8);
`endif

      // Read-modify-write keeps the larger score.
      preload(6'd5, 6'd40, 6'd40, 6'd10, 6'd0, 6'd0, 6'd0, 6'd39);
      do_update(3'd3, 6'd25);
      check("mem3_raised", int'(mem[3]), 25);
      do_update(3'd3, 6'd12);
      check("mem3_kept", int'(mem[3]), 25);

      preload(6'd5, 6'd40, 6'd40, 6'd7, 6'd0, 6'd0, 6'd0, 6'd39);
      do_scan();
      preload(6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0);
      do_scan();
      preload(6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7, 6'd63);
      do_scan();
      preload(6'd63, 6'd0, 6'd63, 6'd0, 6'd0, 6'd0, 6'd0, 6'd63);
      do_scan();

      // Arbitration: last grant was a scan, so update wins this tie.
      preload(6'd9, 6'd3, 6'd3, 6'd3, 6'd3, 6'd3, 6'd3, 6'd3);
      tie_pair(1'b1, 3'd5, 6'd50);
      do_update(3'd2, 6'd60);
      tie_pair(1'b0, 3'd6, 6'd61);
      check("mem6_written", int'(mem[6]), 61);

      // Reset mid-scan at address 4.
      scan_req = 1'b1;
      n = 0;
      while (ram_addr != 3'd4 && n < 20) begin
         @(posedge clock); @(negedge clock); n++;
      end
      check("abort_reach_addr4", int'(ram_addr), 4);
      rst = 1'b0; scan_req = 1'b0;
      #1;
      check("abort_busy_in_rst", int'(busy), 0);
      check("abort_wren_in_rst", int'(ram_wren), 0);
      @(negedge clock);
      rst = 1'b1;
      #1;
      check("abort_max_id", int'(max_id), 0);
      check("abort_max_score", int'(max_score), 0);
`ifdef SCORE_CLEAR_EN
      check("abort_busy_after", int'(busy), 1);
      repeat (8) @(negedge clock);
      for (int i = 0; i < 8; i++) model_mem[i] = 6'd0;
`else
      check("abort_busy_after", int'(busy), 0);
`endif
      writes = 0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clock);
         if (scan_done) writes++;
      end
      check("abort_no_done", writes, 0);
      tie_pair(1'b1, 3'd0, 6'd33);
      do_scan();

      check("upd_queue_empty", upd_q.size(), 0);
      check("scan_queue_empty", scan_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got 1 expected 0");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
